// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial memory controller: access size codes,
// controller state encoding and requesting-channel identifiers.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef enum logic {
        CH_IF = 1'b0,
        CH_D  = 1'b1
    } chan_e;

endpackage

// File: rtl/mem_ctrl_fetch_buf.sv
// Single-entry fetch buffer: remembers the last fetched word and its start
// address; a store anywhere invalidates it.
module mem_ctrl_fetch_buf
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    output logic                  hit_o,
    output logic [LEN-1:0]        data_o,
    input  logic                  fill_i,
    input  logic [ADDR_WIDTH-1:0] fill_addr_i,
    input  logic [LEN-1:0]        fill_data_i,
    input  logic                  inv_i
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] tag_q, tag_d;
    logic [LEN-1:0]        data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (inv_i) begin
            valid_d = 1'b0;
        end else if (fill_i) begin
            valid_d = 1'b1;
            tag_d   = fill_addr_i;
            data_d  = fill_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_addr_i);
    assign data_o = data_q;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial two-channel (fetch / data) controller for a byte-wide memory.
// Optional fetch buffer enabled with `define MEM_CTRL_FETCH_BUF_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32,
    parameter int BYTE_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [LEN-1:0]        if_inst,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_sign,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LEN-1:0]        d_wdata,
    output logic [LEN-1:0]        d_rdata,
    output logic                  d_done,
    input  logic [BYTE_SIZE-1:0]  mem_din,
    output logic [BYTE_SIZE-1:0]  mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr
);

    localparam int NBYTES = LEN / BYTE_SIZE;
    localparam int CW     = $clog2(NBYTES + 1);
    typedef logic [CW-1:0] cnt_t;

    function automatic cnt_t size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return cnt_t'(1);
            SIZE_HALF: return cnt_t'(2);
            default:   return cnt_t'(NBYTES);
        endcase
    endfunction

    function automatic logic [LEN-1:0] extend(input logic [LEN-1:0] w, input cnt_t n,
                                              input logic sgn);
        logic [LEN-1:0] res;
        logic           msb;
        int unsigned    nb;
        nb  = 32'(n) * BYTE_SIZE;
        res = w;
        msb = 1'b0;
        for (int unsigned i = 0; i < LEN; i++)
            if (i + 1 == nb) msb = w[i];
        for (int unsigned i = 0; i < LEN; i++)
            if (i >= nb) res[i] = sgn & msb;
        return res;
    endfunction

    state_e                state_q, state_d;
    chan_e                 chan_q, chan_d;
    cnt_t                  cnt_q, cnt_d, n_q, n_d;
    logic                  sign_q, sign_d;
    logic [LEN-1:0]        wdata_q, wdata_d, data_q, data_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [BYTE_SIZE-1:0]  mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  if_done_q, if_done_d, d_done_q, d_done_d;
    logic [LEN-1:0]        if_inst_q, if_inst_d, d_rdata_q, d_rdata_d;

    logic                  rd_start, last;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [LEN-1:0]        rd_word;
    logic                  fb_hit;
    logic [LEN-1:0]        fb_data;

    assign last = (cnt_q == n_q - cnt_t'(1));

    always_comb begin
        rd_word = data_q;
        for (int unsigned b = 0; b < NBYTES; b++)
            if (b == 32'(cnt_q)) rd_word[b*BYTE_SIZE +: BYTE_SIZE] = mem_din;
    end

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        sign_d     = sign_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_inst_d  = if_inst_q;
        d_rdata_d  = d_rdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        rd_start   = 1'b0;
        rd_addr    = mem_addr_q;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                data_d = '0;
                if (d_req) begin
                    chan_d = CH_D;
                    sign_d = d_sign;
                    n_d    = size_bytes(d_size);
                    if (d_size == SIZE_RSVD) begin
                        d_rdata_d = '0;
                        d_done_d  = 1'b1;
                        state_d   = DONE;
                    end else if (d_we) begin
                        mem_addr_d = d_addr;
                        mem_dout_d = d_wdata[BYTE_SIZE-1:0];
                        wdata_d    = d_wdata >> BYTE_SIZE;
                        mem_wr_d   = 1'b1;
                        state_d    = WR;
                    end else begin
                        rd_start = 1'b1;
                        rd_addr  = d_addr;
                        state_d  = RD;
                    end
                end else if (if_req) begin
                    chan_d = CH_IF;
                    sign_d = 1'b0;
                    n_d    = cnt_t'(NBYTES);
                    if (fb_hit) begin
                        if_inst_d = fb_data;
                        if_done_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        rd_start = 1'b1;
                        rd_addr  = if_addr;
                        state_d  = RD;
                    end
                end
                // Byte 0's address goes out combinationally this cycle, so the register runs one ahead.
                if (rd_start)
                    mem_addr_d = (n_d > cnt_t'(1)) ? rd_addr + ADDR_WIDTH'(1) : rd_addr;
            end
            RD: begin
                if (last) begin
                    state_d = DONE;
                    if (chan_q == CH_D) begin
                        d_rdata_d = extend(rd_word, n_q, sign_q);
                        d_done_d  = 1'b1;
                    end else begin
                        if_inst_d = rd_word;
                        if_done_d = 1'b1;
                    end
                end else begin
                    data_d = rd_word;
                    cnt_d  = cnt_q + cnt_t'(1);
                    if (cnt_q + cnt_t'(2) < n_q) mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                end
            end
            WR: begin
                if (last) begin
                    mem_wr_d = 1'b0;
                    d_done_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                    mem_dout_d = wdata_q[BYTE_SIZE-1:0];
                    wdata_d    = wdata_q >> BYTE_SIZE;
                    cnt_d      = cnt_q + cnt_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            chan_q     <= CH_IF;
            cnt_q      <= '0;
            n_q        <= '0;
            sign_q     <= 1'b0;
            wdata_q    <= '0;
            data_q     <= '0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_inst_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            sign_q     <= sign_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_inst_q  <= if_inst_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef MEM_CTRL_FETCH_BUF_EN
    logic fb_fill, fb_inv;
    assign fb_inv  = (state_q == IDLE) && d_req && d_we && (d_size != SIZE_RSVD);
    assign fb_fill = (state_q == RD) && (chan_q == CH_IF) && last;

    // On the last fetch byte mem_addr_q sits at A+NBYTES-1.
    mem_ctrl_fetch_buf #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN       (LEN)
    ) u_fetch_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_addr_i(if_addr),
        .hit_o        (fb_hit),
        .data_o       (fb_data),
        .fill_i       (fb_fill),
        .fill_addr_i  (mem_addr_q - ADDR_WIDTH'(NBYTES - 1)),
        .fill_data_i  (rd_word),
        .inv_i        (fb_inv)
    );
`else
    assign fb_hit  = 1'b0;
    assign fb_data = '0;
`endif

    assign mem_addr = rd_start ? rd_addr : mem_addr_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign if_inst  = if_inst_q;
    assign d_done   = d_done_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide synchronous memory model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_done, d_req, d_we, d_sign, d_done, mem_wr;
    logic [16:0] if_addr, d_addr, mem_addr;
    logic [1:0]  d_size;
    logic [31:0] if_inst, d_wdata, d_rdata;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0]  mem [0:(1<<17)-1];
    logic        pre_done = 1'b0;

    int          n_pass = 0;
    int          n_total = 0;
    int          nwr;
    logic [16:0] wa [0:7];
    logic [7:0]  wdat [0:7];

    mem_ctrl #(.ADDR_WIDTH(17), .LEN(32), .BYTE_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sign(d_sign), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_addr(mem_addr), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!pre_done) begin
            mem[17'h100] <= 8'h78; mem[17'h101] <= 8'h56;
            mem[17'h102] <= 8'h34; mem[17'h103] <= 8'h12;
            mem[17'h200] <= 8'h80; mem[17'h210] <= 8'h34; mem[17'h211] <= 8'hF2;
            mem[17'h1FFFF] <= 8'hAA; mem[17'h0] <= 8'hBB;
            mem[17'h1] <= 8'hCC; mem[17'h2] <= 8'hDD;
            mem[17'h300] <= 8'h00; mem[17'h301] <= 8'h00; mem[17'h302] <= 8'h5A;
            mem[17'h500] <= 8'h00; mem[17'h501] <= 8'h99; mem[17'h400] <= 8'h00;
            pre_done <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_dout;
        end
        mem_din <= mem[mem_addr];
    end

    task automatic run_d(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [16:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd);
        @(negedge clk);
        d_we = we; d_size = sz; d_sign = sg; d_addr = a; d_wdata = wd; d_req = 1'b1;
        lat = 0; rd = '0; nwr = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                d_addr = ~a; d_wdata = ~wd; d_sign = ~sg;
            end
            if (mem_wr) begin
                if (nwr < 8) begin wa[nwr] = mem_addr; wdat[nwr] = mem_dout; end
                nwr++;
            end
            if (d_done) begin lat = k; rd = d_rdata; break; end
        end
        @(negedge clk);
        d_req = 1'b0;
    endtask

    task automatic run_f(input logic [16:0] a, output int lat, output logic [31:0] inst,
                         output int nchg);
        logic [16:0] a0;
        @(negedge clk);
        a0 = mem_addr; if_addr = a; if_req = 1'b1;
        lat = 0; inst = '0; nchg = 0;
        #1 if (mem_addr !== a0) nchg++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (mem_addr !== a0) nchg++;
            if (k == 1) if_addr = ~a;
            if (if_done) begin lat = k; inst = if_inst; break; end
        end
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_total += 7;
        if (mem_wr   !== 1'b0)  $display("FAIL reset_mem_wr got %h want 0", mem_wr);   else n_pass++;
        if (mem_addr !== 17'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
        if (mem_dout !== 8'h0)  $display("FAIL reset_mem_dout got %h want 0", mem_dout); else n_pass++;
        if (if_done  !== 1'b0)  $display("FAIL reset_if_done got %h want 0", if_done);   else n_pass++;
        if (d_done   !== 1'b0)  $display("FAIL reset_d_done got %h want 0", d_done);     else n_pass++;
        if (if_inst  !== 32'h0) $display("FAIL reset_if_inst got %h want 0", if_inst);   else n_pass++;
        if (d_rdata  !== 32'h0) $display("FAIL reset_d_rdata got %h want 0", d_rdata);   else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        int lat, nchg;
        logic [31:0] inst;
        run_f(17'h100, lat, inst, nchg);
        n_total += 2;
        if (lat !== 5) $display("FAIL fetch_latency got %0d want 5", lat); else n_pass++;
        if (inst !== 32'h12345678) $display("FAIL fetch_inst got %h want 12345678", inst); else n_pass++;
    endtask

    task automatic test_load();
        int lat;
        logic [31:0] rd;
        run_d(1'b0, 2'b00, 1'b1, 17'h200, 32'h0, lat, rd);
        n_total += 2;
        if (lat !== 2) $display("FAIL lb_signed_latency got %0d want 2", lat); else n_pass++;
        if (rd !== 32'hFFFFFF80) $display("FAIL lb_signed_data got %h want ffffff80", rd); else n_pass++;
        run_d(1'b0, 2'b00, 1'b0, 17'h200, 32'h0, lat, rd);
        n_total += 2;
        if (lat !== 2) $display("FAIL lb_unsigned_latency got %0d want 2", lat); else n_pass++;
        if (rd !== 32'h00000080) $display("FAIL lb_unsigned_data got %h want 00000080", rd); else n_pass++;
        run_d(1'b0, 2'b01, 1'b1, 17'h210, 32'h0, lat, rd);
        n_total += 2;
        if (lat !== 3) $display("FAIL lh_signed_latency got %0d want 3", lat); else n_pass++;
        if (rd !== 32'hFFFFF234) $display("FAIL lh_signed_data got %h want fffff234", rd); else n_pass++;
        run_d(1'b0, 2'b01, 1'b0, 17'h210, 32'h0, lat, rd);
        n_total += 1;
        if (rd !== 32'h0000F234) $display("FAIL lh_unsigned_data got %h want 0000f234", rd); else n_pass++;
        run_d(1'b0, 2'b10, 1'b1, 17'h1FFFF, 32'h0, lat, rd);
        n_total += 2;
        if (lat !== 5) $display("FAIL lw_wrap_latency got %0d want 5", lat); else n_pass++;
        if (rd !== 32'hDDCCBBAA) $display("FAIL lw_wrap_data got %h want ddccbbaa", rd); else n_pass++;
    endtask

    task automatic test_store();
        int lat;
        logic [31:0] rd;
        run_d(1'b1, 2'b01, 1'b0, 17'h300, 32'hABCD1234, lat, rd);
        n_total += 8;
        if (lat !== 3) $display("FAIL sh_latency got %0d want 3", lat); else n_pass++;
        if (nwr !== 2) $display("FAIL sh_write_count got %0d want 2", nwr); else n_pass++;
        if (wa[0] !== 17'h300) $display("FAIL sh_addr0 got %h want 00300", wa[0]); else n_pass++;
        if (wdat[0] !== 8'h34) $display("FAIL sh_data0 got %h want 34", wdat[0]); else n_pass++;
        if (wa[1] !== 17'h301) $display("FAIL sh_addr1 got %h want 00301", wa[1]); else n_pass++;
        if (wdat[1] !== 8'h12) $display("FAIL sh_data1 got %h want 12", wdat[1]); else n_pass++;
        if (mem[17'h302] !== 8'h5A) $display("FAIL sh_untouched got %h want 5a", mem[17'h302]); else n_pass++;
        if (mem[17'h301] !== 8'h12) $display("FAIL sh_mem301 got %h want 12", mem[17'h301]); else n_pass++;
    endtask

    task automatic test_reserved();
        int lat;
        logic [31:0] rd;
        run_d(1'b1, 2'b11, 1'b1, 17'h300, 32'hFFFFFFFF, lat, rd);
        n_total += 3;
        if (lat !== 1) $display("FAIL rsvd_latency got %0d want 1", lat); else n_pass++;
        if (rd !== 32'h0) $display("FAIL rsvd_data got %h want 0", rd); else n_pass++;
        if (nwr !== 0) $display("FAIL rsvd_writes got %0d want 0", nwr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dl, il;
        logic [31:0] drd, inst;
        dl = 0; il = 0; drd = '0; inst = '0;
        @(negedge clk);
        d_we = 1'b0; d_size = 2'b00; d_sign = 1'b0; d_addr = 17'h200; d_req = 1'b1;
        if_addr = 17'h100; if_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (if_done) begin il = k; inst = if_inst; break; end
            if (d_done && dl == 0) begin
                dl = k; drd = d_rdata;
                @(negedge clk);
                d_req = 1'b0;
            end
        end
        @(negedge clk);
        if_req = 1'b0;
        n_total += 4;
        if (dl !== 2) $display("FAIL arb_d_latency got %0d want 2", dl); else n_pass++;
        if (drd !== 32'h80) $display("FAIL arb_d_data got %h want 00000080", drd); else n_pass++;
        if (il !== 8) $display("FAIL arb_if_latency got %0d want 8", il); else n_pass++;
        if (inst !== 32'h12345678) $display("FAIL arb_if_inst got %h want 12345678", inst); else n_pass++;
    endtask

    task automatic test_reset_mid_store();
        int lat, bad;
        logic [31:0] rd;
        @(negedge clk);
        d_we = 1'b1; d_size = 2'b10; d_sign = 1'b0; d_addr = 17'h500; d_wdata = 32'h11223344;
        d_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        n_total += 2;
        if (mem_wr !== 1'b1) $display("FAIL rst_pre_wr got %h want 1", mem_wr); else n_pass++;
        if (mem_addr !== 17'h501) $display("FAIL rst_pre_addr got %h want 00501", mem_addr); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total += 3;
        if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr got %h want 0", mem_wr); else n_pass++;
        if (mem_addr !== 17'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else n_pass++;
        if (d_done !== 1'b0) $display("FAIL rst_d_done got %h want 0", d_done); else n_pass++;
        d_req = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (d_done !== 1'b0 || mem_wr !== 1'b0) bad++;
        end
        n_total += 1;
        if (bad !== 0) $display("FAIL rst_quiet got %0d active cycles want 0", bad); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        n_total += 2;
        if (mem[17'h500] !== 8'h44) $display("FAIL rst_byte0 got %h want 44", mem[17'h500]); else n_pass++;
        if (mem[17'h501] !== 8'h99) $display("FAIL rst_byte1 got %h want 99", mem[17'h501]); else n_pass++;
        run_d(1'b0, 2'b00, 1'b0, 17'h500, 32'h0, lat, rd);
        n_total += 2;
        if (lat !== 2) $display("FAIL rst_after_latency got %0d want 2", lat); else n_pass++;
        if (rd !== 32'h44) $display("FAIL rst_after_data got %h want 00000044", rd); else n_pass++;
    endtask

    task automatic test_fetch_buf();
        int lat, nchg, exp_lat;
        logic [31:0] inst, rd;
`ifdef MEM_CTRL_FETCH_BUF_EN
        exp_lat = 1;
`else
        exp_lat = 5;
`endif
        run_f(17'h100, lat, inst, nchg);
        n_total += 1;
        if (lat !== 5) $display("FAIL fb_first_latency got %0d want 5", lat); else n_pass++;
        run_f(17'h100, lat, inst, nchg);
        n_total += 2;
        if (lat !== exp_lat) $display("FAIL fb_second_latency got %0d want %0d", lat, exp_lat); else n_pass++;
        if (inst !== 32'h12345678) $display("FAIL fb_second_inst got %h want 12345678", inst); else n_pass++;
`ifdef MEM_CTRL_FETCH_BUF_EN
        n_total += 1;
        if (nchg !== 0) $display("FAIL fb_hit_addr_activity got %0d want 0", nchg); else n_pass++;
`endif
        run_d(1'b1, 2'b00, 1'b0, 17'h400, 32'h5, lat, rd);
        run_f(17'h100, lat, inst, nchg);
        n_total += 2;
        if (lat !== 5) $display("FAIL fb_after_store_latency got %0d want 5", lat); else n_pass++;
        if (inst !== 32'h12345678) $display("FAIL fb_after_store_inst got %h want 12345678", inst); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = '0; d_sign = 1'b0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_reserved();
        test_back_to_back();
        test_reset_mid_store();
        test_fetch_buf();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Byte-serial memory controller between the CPU core and single-port byte-wide main memory. It replaces the fixed 4-byte counter scheme with a parametrised, handshaked, two-channel arbiter:
- instruction-fetch channel and data channel;
- variable access size (byte/half/word), with sign or zero extension on load;
- correctly sized stores.

It sits between the IF/MEM stages and the memory port.

Parameters:
ADDR_WIDTH, 17, byte-address width of main memory
LEN, 32, CPU word width; must be a multiple of BYTE_SIZE
BYTE_SIZE, 8, memory data width
NBYTES, LEN/BYTE_SIZE, bytes per word (derived, localparam)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_done
if_addr  in  ADDR_WIDTH  fetch byte address
if_done  out  1  one-cycle pulse; if_inst valid this cycle
if_inst  out  LEN  fetched instruction, little-endian
d_req  in  1  data request; held high until d_done
d_we  in  1  1 = store, 0 = load
d_size  in  2  00 byte, 01 half, 10 word, 11 reserved
d_sign  in  1  load sign-extend when 1, zero-extend when 0
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  LEN  store data; low bytes used
d_rdata  out  LEN  extended load result
d_done  out  1  one-cycle pulse; access complete, d_rdata valid for loads
mem_din  in  BYTE_SIZE  byte returned by memory; valid one cycle after address
mem_dout  out  BYTE_SIZE  byte to write
mem_addr  out  ADDR_WIDTH  memory address
mem_wr  out  1  1 = write mem_dout to mem_addr this cycle

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and any in-flight access is aborted.
  - All outputs go to 0: mem_wr, mem_addr, mem_dout, if_done, d_done, if_inst, d_rdata.
  - Byte counter cleared.
- States:
  - IDLE: accepts a request.
  - RD: issue address, collect bytes.
  - WR: drive bytes.
  - DONE: one-cycle done pulse, then back to IDLE.
- Arbitration in IDLE: d_req has priority over if_req. A losing request stays pending; no request is dropped.
- Requests are sampled only in IDLE. Address, size, sign and wdata are latched on accept; later input changes are ignored until done.
- N = bytes for the access: 1 / 2 / NBYTES for byte / half / word. Fetch is always NBYTES.
- Read timing:
  - Accept cycle drives mem_addr=A.
  - Each following cycle drives A+k and captures mem_din as byte k-1.
  - The last byte is captured N cycles after accept, and done pulses that same edge.
  - Latency from accept edge to done = N+1 cycles.
- Write timing:
  - Byte k is driven with mem_addr=A+k, mem_wr=1, for k=0..N-1 in consecutive cycles.
  - Done pulses the cycle after the last byte. Latency = N+1.
- Addresses wrap modulo 2^ADDR_WIDTH (A+k truncated).
- Load result: bytes assembled little-endian into the low N bytes. Upper bits are copies of bit N*BYTE_SIZE-1 when d_sign=1, else 0.
- d_size=11 reserved: no memory cycle, d_done next cycle, d_rdata=0.
- mem_wr is high only in WR; 0 in all other states. mem_addr holds its last value when idle.
- Done pulses last exactly one cycle. The requester must drop req in the done cycle or be re-served.
- Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE.

Optional Feature:
MEM_CTRL_FETCH_BUF_EN
- With the macro: single-entry fetch buffer holding tag (word address) and word.
  - A fetch whose address equals a valid tag completes from the buffer: if_done 1 cycle after accept, no memory cycles.
  - Any store invalidates the buffer.
  - Reset clears the valid bit.
- Without the macro: every fetch goes to memory.

Decomposition:
- Package mem_ctrl_pkg:
  - size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD;
  - state encoding IDLE/RD/WR/DONE;
  - channel id constants.
- Sub-module mem_ctrl_fetch_buf (tag/valid/data, hit compare, invalidate), instantiated only under the macro.

Test Plan:
- Memory preloaded 0x100..0x103 = 78 56 34 12; if_req addr 0x100 -> if_done at accept+5, if_inst=0x12345678.
- Load byte signed at 0x200 holding 0x80 -> d_done at accept+2, d_rdata=0xFFFFFF80; unsigned -> 0x00000080.
- Store half 0xABCD1234 at 0x300 -> mem_wr 2 cycles: (0x300,0x34), (0x301,0x12); d_done next cycle; 0x302 unchanged.
- if_req and d_req rise together -> data access served first; fetch accepted in the cycle after d_done; both complete.
- rst_n low during the 2nd byte of a word store -> mem_wr=0 immediately; no done pulse; IDLE after release.
- With MEM_CTRL_FETCH_BUF_EN: fetch 0x100 twice -> second fetch done in 1 cycle with no mem_addr activity; store to 0x400, then fetch 0x100 -> full 5-cycle memory read.
